// File: rtl/awg_pkg.sv
// Shared definitions for the triangle-generator sweep controller.
// Holds the config register map, mode bit positions, FSM state encoding
// and sweep direction constants.
package awg_pkg;

  localparam logic [2:0] REG_FSTART = 3'd0;
  localparam logic [2:0] REG_FSTOP  = 3'd1;
  localparam logic [2:0] REG_FSTEP  = 3'd2;
  localparam logic [2:0] REG_DWELL  = 3'd3;
  localparam logic [2:0] REG_AMP    = 3'd4;
  localparam logic [2:0] REG_PHASE  = 3'd5;
  localparam logic [2:0] REG_MODE   = 3'd6;

  localparam int MODE_LOOP   = 0;
  localparam int MODE_BOUNCE = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/awg_dwell_timer.sv
// Dwell timer: counts cycles spent on one frequency step.
//   clk, rst   : clock, synchronous active-high reset
//   en_i       : count this cycle
//   clr_i      : force the count back to zero (wins over en_i)
//   limit_i    : terminal count; a step lasts limit_i+1 cycles
//   expire_o   : high in the last cycle of a step
module awg_dwell_timer #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          clr_i,
  input  logic [DW-1:0] limit_i,
  output logic          expire_o
);

  logic [DW-1:0] cnt_q, cnt_d;

  assign expire_o = en_i && (cnt_q == limit_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = expire_o ? '0 : cnt_q + DW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/awg_sweep_ctrl.sv
// Sweep scheduler / config front-end for the triangle generator.
//   clk, rst           : clock, synchronous active-high reset
//   cfg_wr/addr/data   : shadow register writes (never touch a running sweep)
//   start, stop        : sweep commands (stop wins when both are set)
//   busy, done         : RUN indication, one-shot completion pulse
//   en, freq, amp, phase : generator controls, driven from the active copy
module awg_sweep_ctrl
  import awg_pkg::*;
#(
  parameter int FW = 12,
  parameter int DW = 16,
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_wr,
  input  logic [2:0]    cfg_addr,
  input  logic [15:0]   cfg_data,
  input  logic          start,
  input  logic          stop,
  output logic          busy,
  output logic          done,
  output logic          en,
  output logic [FW-1:0] freq,
  output logic [2:0]    amp,
  output logic [PW-1:0] phase
);

  // shadow (software-visible) and active (sweep-owned) copies
  logic [FW-1:0] s_fstart_q, s_fstop_q, s_fstep_q;
  logic [DW-1:0] s_dwell_q;
  logic [2:0]    s_amp_q;
  logic [PW-1:0] s_phase_q;
  logic [1:0]    s_mode_q;

  logic [FW-1:0] a_fstart_q, a_fstop_q, a_fstep_q;
  logic [DW-1:0] a_dwell_q;
  logic [2:0]    a_amp_q;
  logic [PW-1:0] a_phase_q;
  logic [1:0]    a_mode_q;

  state_e        state_q, state_d;
  dir_e          dir_q, dir_d;
  logic [FW-1:0] freq_q, freq_d;
  logic          load;
  logic          expire;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_fstart_q <= '0;
      s_fstop_q  <= '0;
      s_fstep_q  <= FW'(1);
      s_dwell_q  <= '0;
      s_amp_q    <= 3'd1;
      s_phase_q  <= '0;
      s_mode_q   <= '0;
    end else if (cfg_wr) begin
      case (cfg_addr)
        REG_FSTART: s_fstart_q <= cfg_data[FW-1:0];
        REG_FSTOP:  s_fstop_q  <= cfg_data[FW-1:0];
        // zero step would stall the sweep forever; zero amp divides by zero downstream
        REG_FSTEP:  s_fstep_q  <= (cfg_data[FW-1:0] == '0) ? FW'(1) : cfg_data[FW-1:0];
        REG_DWELL:  s_dwell_q  <= cfg_data[DW-1:0];
        REG_AMP:    s_amp_q    <= (cfg_data[2:0] == 3'd0) ? 3'd1 : cfg_data[2:0];
        REG_PHASE:  s_phase_q  <= cfg_data[PW-1:0];
        REG_MODE:   s_mode_q   <= cfg_data[1:0];
        default: ;
      endcase
    end
  end

  awg_dwell_timer #(.DW(DW)) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .en_i     (state_q == ST_RUN),
    .clr_i    (state_q != ST_RUN),
    .limit_i  (a_dwell_q),
    .expire_o (expire)
  );

  // step arithmetic one bit wider so neither direction can wrap
  logic [FW:0]   sum, diff;
  logic [FW-1:0] up_val, dn_val;
  logic          degen, bounce, loop;

  assign sum    = {1'b0, freq_q} + {1'b0, a_fstep_q};
  assign diff   = {1'b0, freq_q} - {1'b0, a_fstep_q};
  assign up_val = (sum > {1'b0, a_fstop_q}) ? a_fstop_q : sum[FW-1:0];
  assign dn_val = (diff[FW] || (diff[FW-1:0] < a_fstart_q)) ? a_fstart_q : diff[FW-1:0];
  assign degen  = (a_fstart_q >= a_fstop_q);
  assign bounce = a_mode_q[MODE_BOUNCE];
  assign loop   = a_mode_q[MODE_LOOP];

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    freq_d  = freq_q;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: if (start && !stop) begin
        state_d = ST_RUN;
        load    = 1'b1;
        freq_d  = s_fstart_q;
        dir_d   = DIR_UP;
      end
      ST_RUN: begin
        if (stop) state_d = ST_IDLE;
        else if (expire) begin
          // empty range: park on f_start; repeating modes never finish
          if (degen) begin
            if (!(loop || bounce)) state_d = ST_DONE;
          end else if (dir_q == DIR_UP) begin
            if (freq_q < a_fstop_q) freq_d = up_val;
            else if (bounce) begin
              dir_d  = DIR_DOWN;
              freq_d = dn_val;
            end else if (loop) freq_d = a_fstart_q;
            else state_d = ST_DONE;
          end else begin
            if (freq_q > a_fstart_q) freq_d = dn_val;
            else begin
              dir_d  = DIR_UP;
              freq_d = up_val;
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      dir_q      <= DIR_UP;
      freq_q     <= '0;
      a_fstart_q <= '0;
      a_fstop_q  <= '0;
      a_fstep_q  <= FW'(1);
      a_dwell_q  <= '0;
      a_amp_q    <= 3'd1;
      a_phase_q  <= '0;
      a_mode_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      freq_q  <= freq_d;
      if (load) begin
        a_fstart_q <= s_fstart_q;
        a_fstop_q  <= s_fstop_q;
        a_fstep_q  <= s_fstep_q;
        a_dwell_q  <= s_dwell_q;
        a_amp_q    <= s_amp_q;
        a_phase_q  <= s_phase_q;
        a_mode_q   <= s_mode_q;
      end
    end
  end

  assign en    = (state_q == ST_RUN);
  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);
  assign freq  = freq_q;
  assign amp   = a_amp_q;
  assign phase = a_phase_q;

endmodule

// File: tb/tb_awg_sweep_ctrl.sv
// Directed bench for awg_sweep_ctrl: per-cycle expectation tables plus
// hand-written config/reset sequences.
module tb_awg_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_wr;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        start, stop;
  logic        busy, done, en;
  logic [11:0] freq;
  logic [2:0]  amp;
  logic [7:0]  phase;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  awg_sweep_ctrl #(.FW(12), .DW(16), .PW(8)) dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .stop(stop), .busy(busy), .done(done), .en(en),
    .freq(freq), .amp(amp), .phase(phase)
  );

  // one row = drive st/sp for n consecutive edges, expect these outputs after each
  typedef struct {
    logic        st, sp;
    int          n;
    logic        en, busy, done;
    logic [11:0] freq;
    logic [2:0]  amp;
    logic [7:0]  phase;
  } vec_t;

  vec_t tab[$];

  function automatic void add(logic st, logic sp, int n, logic e, logic b, logic d,
                              logic [11:0] f, logic [2:0] a, logic [7:0] p);
    vec_t v;
    v.st = st; v.sp = sp; v.n = n; v.en = e; v.busy = b; v.done = d;
    v.freq = f; v.amp = a; v.phase = p;
    tab.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int idx, input logic e, input logic b,
                     input logic d, input logic [11:0] f, input logic [2:0] a,
                     input logic [7:0] p);
    total++;
    if ({en, busy, done, freq, amp, phase} !== {e, b, d, f, a, p}) begin
      bad++;
      $display("FAIL %s #%0d: got en=%b busy=%b done=%b freq=%0d amp=%0d phase=%0h, want en=%b busy=%b done=%b freq=%0d amp=%0d phase=%0h",
               tag, idx, en, busy, done, freq, amp, phase, e, b, d, f, a, p);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    cfg_wr = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_wr = 1'b0; cfg_addr = '0; cfg_data = '0;
  endtask

  task automatic cfg(input logic [15:0] fs, input logic [15:0] fe, input logic [15:0] stp,
                     input logic [15:0] dw);
    wr(3'd0, fs); wr(3'd1, fe); wr(3'd2, stp); wr(3'd3, dw);
  endtask

  task automatic run_tab(input string tag);
    int k;
    k = 0;
    foreach (tab[i]) begin
      for (int c = 0; c < tab[i].n; c++) begin
        start = tab[i].st; stop = tab[i].sp;
        tick();
        start = 1'b0; stop = 1'b0;
        chk(tag, k, tab[i].en, tab[i].busy, tab[i].done, tab[i].freq, tab[i].amp, tab[i].phase);
        k++;
      end
    end
    tab.delete();
  endtask

  initial begin
    rst = 1'b1; cfg_wr = 1'b0; cfg_addr = '0; cfg_data = '0; start = 1'b0; stop = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("reset", 0, 0, 0, 0, 12'd0, 3'd1, 8'h00);

    // reset in the middle of a sweep
    cfg(16'd100, 16'd130, 16'd10, 16'd2);
    add(1, 0, 1, 1, 1, 0, 12'd100, 3'd1, 8'h00);
    add(0, 0, 2, 1, 1, 0, 12'd100, 3'd1, 8'h00);
    add(0, 0, 2, 1, 1, 0, 12'd110, 3'd1, 8'h00);
    run_tab("pre_rst");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst", 0, 0, 0, 0, 12'd0, 3'd1, 8'h00);
    tick();
    chk("mid_rst", 1, 0, 0, 0, 12'd0, 3'd1, 8'h00);

    // one-shot; upper data bits of f_start must be dropped
    cfg(16'hF064, 16'd130, 16'd10, 16'd2);
    add(1, 0, 1, 1, 1, 0, 12'd100, 3'd1, 8'h00);
    add(0, 0, 2, 1, 1, 0, 12'd100, 3'd1, 8'h00);
    add(0, 0, 3, 1, 1, 0, 12'd110, 3'd1, 8'h00);
    add(0, 0, 3, 1, 1, 0, 12'd120, 3'd1, 8'h00);
    add(0, 0, 3, 1, 1, 0, 12'd130, 3'd1, 8'h00);
    add(0, 0, 1, 0, 0, 1, 12'd130, 3'd1, 8'h00);
    add(0, 0, 2, 0, 0, 0, 12'd130, 3'd1, 8'h00);
    run_tab("oneshot");

    // clamp at top of range, no wrap
    cfg(16'd4090, 16'd4095, 16'd8, 16'd0);
    add(1, 0, 1, 1, 1, 0, 12'd4090, 3'd1, 8'h00);
    add(0, 0, 1, 1, 1, 0, 12'd4095, 3'd1, 8'h00);
    add(0, 0, 1, 0, 0, 1, 12'd4095, 3'd1, 8'h00);
    add(0, 0, 1, 0, 0, 0, 12'd4095, 3'd1, 8'h00);
    run_tab("clamp");

    // empty range, one-shot then bounce
    wr(3'd0, 16'd200); wr(3'd1, 16'd100);
    add(1, 0, 1, 1, 1, 0, 12'd200, 3'd1, 8'h00);
    add(0, 0, 1, 0, 0, 1, 12'd200, 3'd1, 8'h00);
    add(0, 0, 1, 0, 0, 0, 12'd200, 3'd1, 8'h00);
    run_tab("degen");
    wr(3'd6, 16'd2);
    add(1, 0, 1, 1, 1, 0, 12'd200, 3'd1, 8'h00);
    add(0, 0, 4, 1, 1, 0, 12'd200, 3'd1, 8'h00);
    add(0, 1, 1, 0, 0, 0, 12'd200, 3'd1, 8'h00);
    run_tab("degen_bnc");

    // bounce, then stop
    cfg(16'd10, 16'd30, 16'd10, 16'd0);
    add(1, 0, 1, 1, 1, 0, 12'd10, 3'd1, 8'h00);
    add(0, 0, 1, 1, 1, 0, 12'd20, 3'd1, 8'h00);
    add(0, 0, 1, 1, 1, 0, 12'd30, 3'd1, 8'h00);
    add(0, 0, 1, 1, 1, 0, 12'd20, 3'd1, 8'h00);
    add(0, 0, 1, 1, 1, 0, 12'd10, 3'd1, 8'h00);
    add(0, 0, 1, 1, 1, 0, 12'd20, 3'd1, 8'h00);
    add(0, 0, 1, 1, 1, 0, 12'd30, 3'd1, 8'h00);
    add(0, 1, 1, 0, 0, 0, 12'd30, 3'd1, 8'h00);
    add(0, 0, 2, 0, 0, 0, 12'd30, 3'd1, 8'h00);
    run_tab("bounce");

    // amp/phase only follow the shadow copy on a start edge
    wr(3'd6, 16'd0);
    cfg(16'd50, 16'd60, 16'd10, 16'd9);
    wr(3'd4, 16'd5); wr(3'd5, 16'h0010);
    add(1, 0, 1, 1, 1, 0, 12'd50, 3'd5, 8'h10);
    run_tab("cfg_a");
    wr(3'd5, 16'h0040); wr(3'd4, 16'd0);
    add(0, 0, 3, 1, 1, 0, 12'd50, 3'd5, 8'h10);
    add(0, 1, 1, 0, 0, 0, 12'd50, 3'd5, 8'h10);
    add(1, 0, 1, 1, 1, 0, 12'd50, 3'd1, 8'h40);
    add(0, 1, 1, 0, 0, 0, 12'd50, 3'd1, 8'h40);
    add(1, 1, 2, 0, 0, 0, 12'd50, 3'd1, 8'h40);
    run_tab("cfg_b");

    // loop for three periods; a start mid-sweep must be ignored
    wr(3'd6, 16'd1);
    cfg(16'd5, 16'd7, 16'd1, 16'd1);
    add(1, 0, 1, 1, 1, 0, 12'd5, 3'd1, 8'h40);
    add(0, 0, 1, 1, 1, 0, 12'd5, 3'd1, 8'h40);
    add(0, 0, 2, 1, 1, 0, 12'd6, 3'd1, 8'h40);
    add(0, 0, 2, 1, 1, 0, 12'd7, 3'd1, 8'h40);
    add(0, 0, 2, 1, 1, 0, 12'd5, 3'd1, 8'h40);
    add(1, 0, 1, 1, 1, 0, 12'd6, 3'd1, 8'h40);
    add(0, 0, 1, 1, 1, 0, 12'd6, 3'd1, 8'h40);
    add(0, 0, 2, 1, 1, 0, 12'd7, 3'd1, 8'h40);
    add(0, 0, 2, 1, 1, 0, 12'd5, 3'd1, 8'h40);
    add(0, 0, 2, 1, 1, 0, 12'd6, 3'd1, 8'h40);
    add(0, 0, 2, 1, 1, 0, 12'd7, 3'd1, 8'h40);
    add(0, 1, 1, 0, 0, 0, 12'd7, 3'd1, 8'h40);
    add(0, 0, 1, 0, 0, 0, 12'd7, 3'd1, 8'h40);
    run_tab("loop");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
